seq_control_unit: RTL and testbench
===================================

// Module: seq_control_unit
// PURPOSE
//  Multi-cycle FETCH/DECODE/EXECUTE/MEMORY sequencer for the 16-bit core. Drives the datapath
//  strobes (regfile, ALU, PC, IR, memory). Instruction boundaries are set by a memory
//  req/ack handshake, not by fixed delays. Opcode width and memory wait limits are
//  parametrised, and branch conditions are resolved internally from the flags.
// PARAMETERS
//  OP_W        4    opcode width (>=4); opcodes with any bit [OP_W-1:4] set are illegal
//  ALU_FUNC_W  4    alu_func width (>=4); opcode zero-extended onto it
//  MEM_TIMEOUT 15   max wait cycles for mem_ack before bus error (used only with timeout)
//  CNT_W       4    watchdog counter width; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-low reset
//  en          in   1          run enable; sampled only in FETCH before issuing a request
//  op_in       in   OP_W       opcode field from the fetched instruction word (valid with mem_ack in FETCH)
//  immed_in    in   1          immediate-mode bit of the fetched instruction
//  flags_in    in   4          {Z,N,C,V} from the flag register
//  mem_ack     in   1          memory completed current request (1-cycle pulse)
//  ir_load     out  1          latch instruction register
//  pc_inc      out  1          PC <= PC+1
//  pc_load     out  1          PC <= branch/jump target
//  w_en        out  1          register-file write
//  alu_func    out  ALU_FUNC_W ALU operation select
//  immed_sel   out  1          operand B = immediate
//  flag_en     out  1          flag register update
//  mem_sel     out  1          0: address from PC, 1: address from ALU/register
//  mem_req     out  1          memory request, held until mem_ack
//  read_write  out  1          1 read, 0 write
//  illegal_op  out  1          1-cycle pulse: illegal opcode decoded
//  bus_err     out  1          1-cycle pulse: memory timeout (0 when feature is compiled out)
//  state       out  3          current state: FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3
// BEHAVIOUR
//  - All outputs are registered. Reset: state=FETCH, read_write=1, every other output 0, IR opcode=0.
//  - FETCH: with en=0, stay in FETCH and keep mem_req=0. With en=1: mem_req=1, mem_sel=0, read_write=1.
//    On mem_ack: capture op_in and immed_in; pulse ir_load and pc_inc; go to DECODE.
//  - An instruction already past FETCH always completes; en=0 only takes effect at the next FETCH.
//  - DECODE (1 cycle): drive alu_func={0,op[3:0]} and immed_sel (held until the next DECODE).
//    An illegal opcode pulses illegal_op and returns to FETCH with no side effects.
//  - EXECUTE (1 cycle), opcode 0..F:
//    0 JMP  : pc_load=1.
//    1-7 ALU, A MOV: w_en=1.
//    F CMP  : flag_en=1.
//    B BE   : pc_load=Z.
//    C BNE  : pc_load=~Z.
//    D BLT  : pc_load=N^V.
//    E BGT  : pc_load=~Z&~(N^V).
//    8 LD, 9 ST: go to MEMORY; all other opcodes go to FETCH.
//    Branches never assert w_en.
//  - MEMORY: mem_req=1, mem_sel=1, read_write=1 (LD) or 0 (ST).
//    On mem_ack: LD pulses w_en, ST does not; drop mem_req; go to FETCH.
//  - Strobes (ir_load, pc_inc, pc_load, w_en, flag_en, illegal_op, bus_err) last exactly 1 cycle.
//  - mem_req rises on entry to the wait state and falls the cycle after mem_ack.
//    A mem_ack seen while mem_req=0 is ignored.
//  - Latency with zero-wait memory (ack the cycle after req), counted from FETCH to the next FETCH:
//    ALU/branch instruction = 4 cycles; LD/ST = 6 cycles.
//  - Reset asserted mid-instruction: immediately return to the reset values; no partial write completes.
//  - state=4..7 is unreachable; if entered, go to FETCH on the next clock.
// CONFIGURATION
//  SEQCTL_MEM_TIMEOUT_EN defined:
//    - A watchdog counts cycles while mem_req=1 and mem_ack=0.
//    - On reaching MEM_TIMEOUT: pulse bus_err, drop mem_req, suppress w_en/ir_load/pc_inc, go to FETCH.
//    - The counter clears on mem_ack or on a state change.
//  SEQCTL_MEM_TIMEOUT_EN undefined:
//    - No counter; waits on mem_ack indefinitely.
//    - bus_err is tied to 0.
// TESTING
//  1. Reset low mid-MEMORY, then release -> state=0, mem_req=0, read_write=1, no w_en pulse.
//  2. en=1, fetch op=1 (ADD), ack after 1 cycle -> ir_load+pc_inc, then w_en=1 with alu_func=1; 4-cycle instruction.
//  3. Fetch B (BE): Z=1 -> pc_load pulse. Fetch C (BNE): Z=1 -> no pc_load, no w_en.
//     Fetch E (BGT): N=0,V=0,Z=0 -> pc_load.
//  4. Fetch 8 (LD), MEMORY ack after 3 wait cycles -> mem_sel=1, read_write=1, w_en one cycle after ack.
//     Fetch 9 (ST) -> read_write=0, no w_en.
//  5. OP_W=5, op=5'h11 -> illegal_op pulse in DECODE, back to FETCH, no w_en/pc_load/flag_en.
//  6. SEQCTL_MEM_TIMEOUT_EN defined, MEM_TIMEOUT=15, mem_ack held 0 -> bus_err after 15 wait cycles,
//     FETCH re-entered. Macro undefined -> mem_req stays 1 for 100+ cycles.

Source files
------------

// File: rtl/seq_control_unit.sv
// ============================================================================
// Module   : seq_control_unit
// Purpose  : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY sequencer for the 16-bit
//            core. Memory watchdog is built only when SEQCTL_MEM_TIMEOUT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_control_unit #(
  parameter int OP_W        = 4,
  parameter int ALU_FUNC_W  = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [OP_W-1:0]       op_i,
  input  logic                  immed_i,
  input  logic [3:0]            flags_i,
  input  logic                  mem_ack_i,
  output logic                  ir_load_o,
  output logic                  pc_inc_o,
  output logic                  pc_load_o,
  output logic                  w_en_o,
  output logic [ALU_FUNC_W-1:0] alu_func_o,
  output logic                  immed_sel_o,
  output logic                  flag_en_o,
  output logic                  mem_sel_o,
  output logic                  mem_req_o,
  output logic                  read_write_o,
  output logic                  illegal_op_o,
  output logic                  bus_err_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEMORY  = 3'd3
  } state_e;

  state_e                  state_q;
  logic [OP_W-1:0]         op_q;
  logic                    immed_q;
  logic                    ir_load_q, pc_inc_q, pc_load_q, w_en_q, flag_en_q;
  logic                    illegal_op_q, bus_err_q;
  logic                    immed_sel_q, mem_sel_q, mem_req_q, read_write_q;
  logic [ALU_FUNC_W-1:0]   alu_func_q;

  logic                    op_illegal;
  logic                    branch_take;
  logic                    timeout;
  logic                    flag_z, flag_n, flag_v;
  logic                    unused_flag_c;

  assign flag_z        = flags_i[3];
  assign flag_n        = flags_i[2];
  assign unused_flag_c = flags_i[1];
  assign flag_v        = flags_i[0];

  generate
    if (OP_W > 4) begin : g_op_ext
      assign op_illegal = |op_q[OP_W-1:4];
    end else begin : g_op_base
      assign op_illegal = 1'b0;
    end
  endgenerate

  always_comb begin
    branch_take = 1'b0;
    case (op_q[3:0])
      4'hB:    branch_take = flag_z;
      4'hC:    branch_take = ~flag_z;
      4'hD:    branch_take = flag_n ^ flag_v;
      4'hE:    branch_take = ~flag_z & ~(flag_n ^ flag_v);
      default: branch_take = 1'b0;
    endcase
  end

`ifdef SEQCTL_MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wdog_q;

  // Fires on the MEM_TIMEOUT-th consecutive cycle of an unanswered request.
  assign timeout = mem_req_q && !mem_ack_i && (wdog_q == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else if (!mem_req_q || mem_ack_i || timeout) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(MEM_TIMEOUT);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      immed_q      <= 1'b0;
      ir_load_q    <= 1'b0;
      pc_inc_q     <= 1'b0;
      pc_load_q    <= 1'b0;
      w_en_q       <= 1'b0;
      flag_en_q    <= 1'b0;
      illegal_op_q <= 1'b0;
      bus_err_q    <= 1'b0;
      alu_func_q   <= '0;
      immed_sel_q  <= 1'b0;
      mem_sel_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      read_write_q <= 1'b1;
    end else begin
      ir_load_q    <= 1'b0;
      pc_inc_q     <= 1'b0;
      pc_load_q    <= 1'b0;
      w_en_q       <= 1'b0;
      flag_en_q    <= 1'b0;
      illegal_op_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_FETCH: begin
          // en is only honoured before the request goes out.
          if (!mem_req_q) begin
            if (en_i) begin
              mem_req_q    <= 1'b1;
              mem_sel_q    <= 1'b0;
              read_write_q <= 1'b1;
            end
          end else if (timeout) begin
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
          end else if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            op_q      <= op_i;
            immed_q   <= immed_i;
            ir_load_q <= 1'b1;
            pc_inc_q  <= 1'b1;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op_illegal) begin
            illegal_op_q <= 1'b1;
            state_q      <= S_FETCH;
          end else begin
            alu_func_q  <= ALU_FUNC_W'(op_q[3:0]);
            immed_sel_q <= immed_q;
            state_q     <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          state_q <= S_FETCH;
          case (op_q[3:0])
            4'h0:                   pc_load_q <= 1'b1;
            4'h8, 4'h9:             state_q   <= S_MEMORY;
            4'hF:                   flag_en_q <= 1'b1;
            4'hB, 4'hC, 4'hD, 4'hE: pc_load_q <= branch_take;
            default:                w_en_q    <= 1'b1;
          endcase
        end
        S_MEMORY: begin
          if (!mem_req_q) begin
            mem_req_q    <= 1'b1;
            mem_sel_q    <= 1'b1;
            read_write_q <= (op_q[3:0] == 4'h8);
          end else if (timeout) begin
            mem_req_q    <= 1'b0;
            mem_sel_q    <= 1'b0;
            read_write_q <= 1'b1;
            bus_err_q    <= 1'b1;
            state_q      <= S_FETCH;
          end else if (mem_ack_i) begin
            mem_req_q    <= 1'b0;
            mem_sel_q    <= 1'b0;
            read_write_q <= 1'b1;
            w_en_q       <= (op_q[3:0] == 4'h8);
            state_q      <= S_FETCH;
          end
        end
        default: begin
          mem_req_q    <= 1'b0;
          mem_sel_q    <= 1'b0;
          read_write_q <= 1'b1;
          state_q      <= S_FETCH;
        end
      endcase
    end
  end

  assign ir_load_o    = ir_load_q;
  assign pc_inc_o     = pc_inc_q;
  assign pc_load_o    = pc_load_q;
  assign w_en_o       = w_en_q;
  assign alu_func_o   = alu_func_q;
  assign immed_sel_o  = immed_sel_q;
  assign flag_en_o    = flag_en_q;
  assign mem_sel_o    = mem_sel_q;
  assign mem_req_o    = mem_req_q;
  assign read_write_o = read_write_q;
  assign illegal_op_o = illegal_op_q;
  assign bus_err_o    = bus_err_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_control_unit.sv
// ============================================================================
// Module   : tb_seq_control_unit
// Purpose  : Directed self-checking bench for seq_control_unit (OP_W=5).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_control_unit;

  logic       clk = 1'b0;
  logic       rst_n, en, immed, mem_ack;
  logic [4:0] op;
  logic [3:0] flags;
  logic       ir_load, pc_inc, pc_load, w_en, immed_sel, flag_en;
  logic       mem_sel, mem_req, read_write, illegal_op, bus_err;
  logic [3:0] alu_func;
  logic [2:0] state;

  integer checks = 0;
  integer errors = 0;

  seq_control_unit #(.OP_W(5), .ALU_FUNC_W(4), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .op_i(op), .immed_i(immed),
    .flags_i(flags), .mem_ack_i(mem_ack), .ir_load_o(ir_load), .pc_inc_o(pc_inc),
    .pc_load_o(pc_load), .w_en_o(w_en), .alu_func_o(alu_func), .immed_sel_o(immed_sel),
    .flag_en_o(flag_en), .mem_sel_o(mem_sel), .mem_req_o(mem_req),
    .read_write_o(read_write), .illegal_op_o(illegal_op), .bus_err_o(bus_err),
    .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH with mem_req=0 and en=1: request goes out, acked next cycle.
  // Returns one cycle after the ack (DUT should then be in DECODE).
  task automatic do_fetch(input logic [4:0] o, input logic im);
    tick();
    mem_ack = 1'b1;
    op      = o;
    immed   = im;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; immed = 1'b0; mem_ack = 1'b0; op = '0; flags = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (read_write !== 1'b1) begin errors++; $display("FAIL reset_rw got %b exp 1", read_write); end
    checks++; if ({ir_load, pc_inc, pc_load, w_en, flag_en, illegal_op, bus_err, mem_sel, mem_req, immed_sel, alu_func} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0", {ir_load, pc_inc, pc_load, w_en, flag_en, illegal_op, bus_err, mem_sel, mem_req, immed_sel, alu_func});
    end
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL en0_no_req got %b exp 0", mem_req); end
  endtask

  task automatic test_alu();
    en = 1'b1;
    do_fetch(5'h01, 1'b1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL alu_decode_state got %0d exp 1", state); end
    checks++; if ({ir_load, pc_inc, mem_req} !== 3'b110) begin errors++; $display("FAIL alu_fetch_strobes got %b exp 110", {ir_load, pc_inc, mem_req}); end
    en = 1'b0;
    tick();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL alu_exec_state got %0d exp 2", state); end
    checks++; if ({alu_func, immed_sel} !== 5'b0001_1) begin errors++; $display("FAIL alu_func got %b exp 00011", {alu_func, immed_sel}); end
    checks++; if ({ir_load, pc_inc, w_en} !== 3'b000) begin errors++; $display("FAIL alu_strobe_len got %b exp 000", {ir_load, pc_inc, w_en}); end
    tick();
    checks++; if ({state, w_en, pc_load} !== 5'b000_10) begin errors++; $display("FAIL alu_wen got %b exp 00010", {state, w_en, pc_load}); end
    tick();
    checks++; if ({state, w_en, mem_req} !== 5'b000_00) begin errors++; $display("FAIL alu_idle got %b exp 00000", {state, w_en, mem_req}); end
    en = 1'b1;
  endtask

  task automatic test_branch();
    logic [4:0] t_op [9];
    logic [3:0] t_fl [9];
    logic [2:0] t_ex [9]; // {pc_load, w_en, flag_en}
    t_op = '{5'h0B, 5'h0C, 5'h0E, 5'h0E, 5'h0D, 5'h0D, 5'h0F, 5'h00, 5'h0A};
    t_fl = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    t_ex = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b001, 3'b100, 3'b010};
    for (int i = 0; i < 9; i++) begin
      flags = t_fl[i];
      do_fetch(t_op[i], 1'b0);
      tick();
      checks++; if (alu_func !== t_op[i][3:0]) begin errors++; $display("FAIL br_alu_func[%0d] got %h exp %h", i, alu_func, t_op[i][3:0]); end
      tick();
      checks++; if ({state, pc_load, w_en, flag_en} !== {3'd0, t_ex[i]}) begin
        errors++; $display("FAIL br_exec[%0d] op %h got %b exp %b", i, t_op[i], {state, pc_load, w_en, flag_en}, {3'd0, t_ex[i]});
      end
    end
  endtask

  task automatic test_mem();
    do_fetch(5'h08, 1'b0);
    tick(); tick();
    checks++; if ({state, mem_req} !== 4'b011_0) begin errors++; $display("FAIL ld_mem_entry got %b exp 0110", {state, mem_req}); end
    tick();
    checks++; if ({mem_req, mem_sel, read_write} !== 3'b111) begin errors++; $display("FAIL ld_req got %b exp 111", {mem_req, mem_sel, read_write}); end
    tick(); tick(); tick();
    mem_ack = 1'b1;
    checks++; if ({state, mem_req, w_en} !== 5'b011_10) begin errors++; $display("FAIL ld_wait got %b exp 01110", {state, mem_req, w_en}); end
    tick();
    mem_ack = 1'b0;
    checks++; if ({state, w_en, mem_req, read_write, mem_sel} !== 7'b000_1010) begin
      errors++; $display("FAIL ld_done got %b exp 0001010", {state, w_en, mem_req, read_write, mem_sel});
    end
    do_fetch(5'h09, 1'b0);
    tick(); tick(); tick();
    checks++; if ({mem_req, mem_sel, read_write} !== 3'b110) begin errors++; $display("FAIL st_req got %b exp 110", {mem_req, mem_sel, read_write}); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if ({state, w_en, mem_req, read_write} !== 6'b000_001) begin
      errors++; $display("FAIL st_done got %b exp 000001", {state, w_en, mem_req, read_write});
    end
  endtask

  task automatic test_illegal();
    do_fetch(5'h11, 1'b0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ill_decode got %0d exp 1", state); end
    en = 1'b0;
    tick();
    checks++; if ({state, illegal_op, w_en, pc_load, flag_en} !== 7'b000_1000) begin
      errors++; $display("FAIL ill_pulse got %b exp 0001000", {state, illegal_op, w_en, pc_load, flag_en});
    end
    tick();
    checks++; if ({state, illegal_op, w_en, pc_load, flag_en} !== 7'd0) begin
      errors++; $display("FAIL ill_after got %b exp 0000000", {state, illegal_op, w_en, pc_load, flag_en});
    end
  endtask

  task automatic test_ack_ignored();
    en = 1'b0; mem_ack = 1'b1; op = 5'h01;
    tick(); tick();
    mem_ack = 1'b0;
    checks++; if ({state, ir_load, pc_inc, mem_req} !== 6'd0) begin
      errors++; $display("FAIL stray_ack got %b exp 000000", {state, ir_load, pc_inc, mem_req});
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_mem();
    do_fetch(5'h08, 1'b0);
    tick(); tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({state, mem_req, read_write, mem_sel} !== 6'b000_010) begin
      errors++; $display("FAIL rst_async got %b exp 000010", {state, mem_req, read_write, mem_sel});
    end
    en = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if ({state, w_en, mem_req, read_write} !== 6'b000_001) begin
      errors++; $display("FAIL rst_release got %b exp 000001", {state, w_en, mem_req, read_write});
    end
    en = 1'b1;
  endtask

  task automatic test_timeout();
    integer drops;
    do_fetch(5'h08, 1'b0);
    tick(); tick(); tick();
    repeat (14) tick();
    checks++; if ({mem_req, bus_err} !== 2'b10) begin errors++; $display("FAIL to_wait got %b exp 10", {mem_req, bus_err}); end
    tick();
`ifdef SEQCTL_MEM_TIMEOUT_EN
    checks++; if ({state, bus_err, mem_req, w_en} !== 6'b000_100) begin
      errors++; $display("FAIL to_buserr got %b exp 000100", {state, bus_err, mem_req, w_en});
    end
    tick();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", bus_err); end
`else
    drops = 0;
    repeat (100) begin
      if (mem_req !== 1'b1 || bus_err !== 1'b0 || state !== 3'd3) drops++;
      tick();
    end
    checks++; if (drops !== 0) begin errors++; $display("FAIL to_hold got %0d exp 0", drops); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_illegal();
    test_ack_ignored();
    test_reset_mid_mem();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
